// File: rtl/booth_mul_sequencer_pkg.sv
// cpu_pkg: shared CPU definitions used by the multiply unit.
//   WORD_W      - datapath word width
//   mul_state_t - multiply sequencer FSM states
//   pp_sel_t    - radix-4 Booth partial-product selection
//   booth_decode - maps a Booth triple {b[i+1], b[i], b[i-1]} to a selection
package cpu_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

  typedef enum logic [2:0] {
    PP_ZERO,
    PP_POS1,
    PP_POS2,
    PP_NEG1,
    PP_NEG2
  } pp_sel_t;

  function automatic pp_sel_t booth_decode(input logic [2:0] triple);
    pp_sel_t sel;
    sel = PP_ZERO;
    case (triple)
      3'b001, 3'b010: sel = PP_POS1;
      3'b011:         sel = PP_POS2;
      3'b100:         sel = PP_NEG2;
      3'b101, 3'b110: sel = PP_NEG1;
      default:        sel = PP_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_mul_sequencer_if.sv
// Handshake/data bundle between the control unit and the Booth multiplier.
//   start/a/b/flush      control unit -> multiplier
//   busy/done/hilo_we/hi/lo  multiplier -> control unit / HI-LO file
interface booth_mul_sequencer_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             hilo_we;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, a, b, flush,
    input  busy, done, hilo_we, hi, lo
  );

  modport slave (
    input  start, a, b, flush,
    output busy, done, hilo_we, hi, lo
  );

endinterface

// File: rtl/booth_mul_sequencer_pp_select.sv
// booth_pp_select: combinational radix-4 Booth partial-product generator.
//   triple  in  3      current Booth bit triple of the multiplier
//   mcand   in  2W     sign-extended (and already shifted) multiplicand
//   pp      out 2W     selected partial product, two's complement
module booth_pp_select
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic [2:0]         triple,
  input  logic [2*WIDTH-1:0] mcand,
  output logic [2*WIDTH-1:0] pp
);

  localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] mcand_x2;

  assign mcand_x2 = mcand << 1;

  always_comb begin
    pp = '0;
    case (booth_decode(triple))
      PP_POS1: pp = mcand;
      PP_POS2: pp = mcand_x2;
      PP_NEG1: pp = ~mcand + ONE;
      PP_NEG2: pp = ~mcand_x2 + ONE;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_sequencer.sv
// booth_mul_sequencer: multi-cycle radix-4 Booth multiplier for MUL.
// Retires one Booth bit-pair per clock; 16 RUN cycles then one DONE cycle.
//   clock   in  1      rising-edge clock
//   clear   in  1      synchronous active-high reset
//   bus     slave      start/a/b/flush in; busy/done/hilo_we/hi/lo out
module booth_mul_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic                  clock,
  input  logic                  clear,
  booth_mul_sequencer_if.slave  bus
);

  localparam int STEPS = WIDTH / 2;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mul_state_t         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH:0]     mplr_q, mplr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] acc_sum;

  booth_pp_select #(.WIDTH(WIDTH)) u_pp_select (
    .triple (mplr_q[2:0]),
    .mcand  (mcand_q),
    .pp     (pp)
  );

  assign acc_sum = acc_q + pp;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        // start beats a simultaneous flush: flush only matters in RUN
        if (bus.start) begin
          mcand_d = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
          mplr_d  = {bus.b, 1'b0};
          acc_d   = '0;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d   = acc_sum;
          mcand_d = mcand_q << 2;
          mplr_d  = {{2{mplr_q[WIDTH]}}, mplr_q[WIDTH:2]};
          count_d = count_q + CNT_ONE;
          if (count_q == LAST_STEP) begin
            // HI/LO take the final sum on the edge into DONE so they
            // are already valid while done/hilo_we are high
            {hi_d, lo_d} = acc_sum;
            state_d      = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      count_q <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.hilo_we = (state_q == S_DONE);
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Scoreboard bench for booth_mul_sequencer: stimulus pushes expected
// {hi,lo} products; a negedge monitor pops and compares on every done.
module tb_booth_mul_sequencer;

  logic clock;
  logic clear;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  logic prev_done = 1'b0;
  logic [63:0] exp_q[$];

  booth_mul_sequencer_if #(.WIDTH(32)) bus ();

  booth_mul_sequencer #(.WIDTH(32)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at cyc=%0d", nm, got, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clock) begin
    logic [63:0] e;
    chk("hilo_we_eq_done", 64'(bus.hilo_we), 64'(bus.done));
    if (bus.done === 1'b1) begin
      chk("done_pulse_width", 64'(prev_done), 64'd0);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done got hi=%h lo=%h exp=no_done at cyc=%0d",
                 bus.hi, bus.lo, cyc);
      end else begin
        e = exp_q.pop_front();
        checks--;
        chk("product", {bus.hi, bus.lo}, e);
      end
    end
    prev_done = bus.done;
  end

  // Call at a negedge; returns at the negedge of the first cycle after accept.
  task automatic issue(input logic [31:0] a_i, input logic [31:0] b_i,
                       input bit push, input logic [63:0] exp_v, input bit fl);
    int guard = 0;
    while (bus.busy !== 1'b0 && guard < 60) begin
      @(negedge clock);
      guard++;
    end
    chk("idle_before_start", 64'(bus.busy), 64'd0);
    bus.a     = a_i;
    bus.b     = b_i;
    bus.start = 1'b1;
    bus.flush = fl;
    if (push) exp_q.push_back(exp_v);
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    acc_cyc   = cyc;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
  endtask

  // Done must appear in cycle 17 after the accept edge (cycle 1 = right after it).
  task automatic wait_done();
    while (bus.done !== 1'b1 && (cyc - acc_cyc) < 60) @(negedge clock);
    chk("done_latency", 64'(cyc - acc_cyc + 1), 64'd17);
  endtask

  task automatic mul(input logic [31:0] a_i, input logic [31:0] b_i, input logic [63:0] exp_v);
    issue(a_i, b_i, 1'b1, exp_v, 1'b0);
    wait_done();
  endtask

  initial begin
    logic [31:0] ra, rb;
    longint      rp;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    clear     = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    clear = 1'b0;
    @(negedge clock);

    // Directed vectors
    mul(32'd3, 32'd5, 64'h00000000_0000000F);
    mul(32'hFFFFFFF9, 32'd6, 64'hFFFFFFFF_FFFFFFD6);
    mul(32'h80000000, 32'h80000000, 64'h40000000_00000000);
    mul(32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001);
    mul(32'h00000000, 32'hFFFFFFFF, 64'h00000000_00000000);
    mul(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001);
    mul(32'hFFFFFFFF, 32'h7FFFFFFF, 64'hFFFFFFFF_80000001);

    // start+flush together in IDLE: start wins
    issue(32'd7, 32'd8, 1'b1, 64'd56, 1'b1);
    wait_done();

    // start while busy is ignored
    issue(32'd2, 32'd3, 1'b1, 64'd6, 1'b0);
    repeat (4) @(negedge clock);
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    wait_done();
    @(negedge clock);
    chk("idle_after_ignored_start", 64'(bus.busy), 64'd0);
    repeat (20) @(negedge clock);

    // flush mid-RUN
    mul(32'd4, 32'd4, 64'd16);
    issue(32'd5, 32'd5, 1'b0, 64'd0, 1'b0);
    repeat (7) @(negedge clock);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_hilo_kept", {bus.hi, bus.lo}, 64'd16);
    repeat (25) @(negedge clock);
    chk("flush_hilo_after", {bus.hi, bus.lo}, 64'd16);

    // clear mid-RUN
    mul(32'd4, 32'd4, 64'd16);
    issue(32'd5, 32'd5, 1'b0, 64'd0, 1'b0);
    repeat (4) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clear_busy", 64'(bus.busy), 64'd0);
    chk("clear_hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (25) @(negedge clock);

    mul(32'd100, 32'hFFFFFF9C, 64'hFFFFFFFF_FFFFD8F0);

    // Random signed pairs against a 64-bit reference product
    for (int i = 0; i < 2500; i++) begin
      ra = $urandom;
      rb = $urandom;
      rp = longint'($signed(ra)) * longint'($signed(rb));
      mul(ra, rb, 64'(rp));
    end

    repeat (5) @(negedge clock);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
